// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory requests,
// in-order prefetch FIFO and IF/ID output register. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int CRW  = CW + 1;
  localparam logic [CRW-1:0] DEPTH_W = CRW'(FIFO_DEPTH);

  typedef logic [CW-1:0] cnt_t;

  // Handshake semantics: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // responses are always accepted (no backpressure) and arrive in request order.

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_cnt_q, drop_cnt_d;
  cnt_t        fifo_count_q, fifo_count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [63:0] fifo_mem [FIFO_DEPTH];
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic           fifo_empty;
  logic           pop;
  logic           push;
  logic           req_hs;
  logic [CRW-1:0] credit_used;
  logic [31:0]    redirect_addr;
  logic [31:0]    head_inst;
  logic [31:0]    head_pc;
  logic           unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_addr = {redirect_pc[31:2], 2'b00};

  assign fifo_empty = (fifo_count_q == '0);
  assign pop        = !id_stall && !fifo_empty && !redirect_valid;
  assign head_inst  = fifo_mem[rd_ptr_q][63:32];
  assign head_pc    = fifo_mem[rd_ptr_q][31:0];

  // Credit counts in-flight requests plus buffered entries, net of this cycle's pop.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count_q} - CRW'(pop);
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign push           = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + cnt_t'(req_hs) - cnt_t'(imem_resp_valid);
    drop_cnt_d    = drop_cnt_q;
    fifo_count_d  = fifo_count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;

    if (redirect_valid) begin
      fetch_pc_d   = redirect_addr;
      resp_pc_d    = redirect_addr;
      fifo_count_d = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      // Everything still in flight belongs to the old path and must be discarded.
      drop_cnt_d   = outstanding_q - cnt_t'(imem_resp_valid);
      id_inst_d    = NOP_INST;
      id_valid_d   = 1'b0;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_resp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - cnt_t'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      fifo_count_d = fifo_count_q + cnt_t'(push) - cnt_t'(pop);
      if (!id_stall) begin
        if (pop) begin
          id_inst_d  = head_inst;
          id_pc_d    = head_pc;
          id_valid_d = 1'b1;
        end else begin
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= RESET_PC;
      id_valid_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_count_q  <= fifo_count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by fifo_count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {imem_resp_data, resp_pc_q};
    end
  end

  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, push};
    perf_bubble_d  = perf_bubble_q + {31'd0, (!id_stall && !pop)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubble_q  <= perf_bubble_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural memory with variable latency, expected-PC stream model
// (sequential from the last reset/redirect target) and a negedge monitor checking outputs.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH),
    .NOP_INST  (NOP_INST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubble    (perf_bubble)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  int          checks;
  int          passes;
  int          cyc;
  int          lat;
  int          first_hs_edge;
  int          first_valid_edge;
  int          valid_cnt;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver + memory model ----------------
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic        rdr;
    logic [31:0] rpc;
    logic        in_rst;
    @(negedge clk);
    hs     = imem_req_valid && imem_req_ready;
    a      = imem_req_addr;
    rdr    = redirect_valid && rst_n;
    rpc    = redirect_pc;
    in_rst = !rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (in_rst) begin
      pend_q.delete();
      exp_q.delete();
      exp_next         = RESET_PC;
      first_hs_edge    = -1;
      first_valid_edge = -1;
    end else begin
      if (hs) begin
        chk("credit_limit", 32'(pend_q.size() + 1 <= FIFO_DEPTH), 32'd1);
        pend_q.push_back('{addr: a, due: cyc + lat - 1});
        if (first_hs_edge < 0) first_hs_edge = cyc;
      end
      if (rdr) begin
        exp_q.delete();
        exp_next = {rpc[31:2], 2'b00};
      end
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall;
  logic        prev_redirect;
  logic        prev_rst;
  logic [31:0] last_inst;
  logic [31:0] last_pc;
  logic        last_valid;

  initial begin
    prev_stall    = 1'b0;
    prev_redirect = 1'b0;
    prev_rst      = 1'b1;
    last_inst     = NOP_INST;
    last_pc       = RESET_PC;
    last_valid    = 1'b0;
  end

  always @(negedge clk) begin
    logic        loaded;
    logic [31:0] e;
    if (!rst_n) begin
      chk("reset_id_valid", {31'd0, id_valid}, 32'd0);
      chk("reset_id_inst", id_inst, NOP_INST);
      chk("reset_id_pc", id_pc, RESET_PC);
      chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end else if (!prev_rst) begin
      loaded = !prev_stall || prev_redirect;
      if (loaded && prev_redirect) chk("redirect_nop", {31'd0, id_valid}, 32'd0);
      if (loaded && id_valid) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_inst", id_inst, mem_data(e));
        end
        valid_cnt++;
        if (first_valid_edge < 0) first_valid_edge = cyc;
      end
      if (!loaded) begin
        chk("hold_inst", id_inst, last_inst);
        chk("hold_pc", id_pc, last_pc);
        chk("hold_valid", {31'd0, id_valid}, {31'd0, last_valid});
      end
      if (!id_valid) chk("nop_when_invalid", id_inst, NOP_INST);
    end
    prev_stall    = id_stall;
    prev_redirect = redirect_valid;
    prev_rst      = !rst_n;
    last_inst     = id_inst;
    last_pc       = id_pc;
    last_valid    = id_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a0;
    int          v0;
    checks           = 0;
    passes           = 0;
    cyc              = 0;
    lat              = 1;
    first_hs_edge    = -1;
    first_valid_edge = -1;
    valid_cnt        = 0;
    exp_next         = RESET_PC;
    rst_n            = 1'b0;
    imem_req_ready   = 1'b1;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = '0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    id_stall         = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;

    // Streaming with 1-cycle memory: latency and full throughput
    repeat (8) tick();
    chk("first_valid_latency", 32'(first_valid_edge - first_hs_edge), 32'd2);
    v0 = valid_cnt;
    repeat (10) tick();
    chk("throughput", 32'(valid_cnt - v0), 32'd10);

    // Three-cycle stall mid-stream
    id_stall = 1'b1;
    repeat (3) tick();
    id_stall = 1'b0;
    v0 = valid_cnt;
    repeat (6) tick();
    chk("resume_after_stall", 32'(valid_cnt - v0 >= 4), 32'd1);

    // 2-cycle memory, redirect with stale responses in flight
    lat = 2;
    repeat (8) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    v0 = valid_cnt;
    repeat (10) tick();
    chk("resume_after_redirect", 32'(valid_cnt > v0), 32'd1);

    // Memory not ready for 4 cycles
    lat = 1;
    imem_req_ready = 1'b0;
    tick();
    a0 = imem_req_addr;
    repeat (4) begin
      tick();
      chk("addr_stable", imem_req_addr, a0);
    end
    chk("drained_valid", {31'd0, id_valid}, 32'd0);
    chk("drained_inst", id_inst, NOP_INST);
    imem_req_ready = 1'b1;
    repeat (4) tick();

    // Address wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    v0 = valid_cnt;
    repeat (12) tick();
    chk("wrap_progress", 32'(valid_cnt - v0 >= 3), 32'd1);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
      end
      lat            = $urandom_range(1, 3);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_stall       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = $urandom;
      tick();
    end

    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    imem_req_ready = 1'b1;
    v0 = valid_cnt;
    repeat (12) tick();
    chk("final_progress", 32'(valid_cnt - v0 >= 8), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
